regfile_wb_arb: RTL and testbench
=================================

// Module: regfile_wb_arb
// PURPOSE
//  Write-port arbiter/sequencer for the single-write-port regfile. Shares regW port between
//  two writeback requesters (A = ALU, B = LSU) using valid/ready handshakes, registers the winning
//  write, and exports a pending-write mask so decode can stall on RAW hazards.
//  Sits between the execute/memory stages and regfile (wen, regW_sel, regW_i).
// PARAMETERS
//  XLEN   32  data width of a register
//  NREG   32  number of architectural registers; select width = $clog2(NREG)
// PORTS
//  clk       in   1               clock; all state updates on rising edge
//  rst       in   1               asynchronous, active-high reset
//  reqA_v    in   1               requester A write valid
//  reqA_sel  in   $clog2(NREG)    requester A destination register
//  reqA_i    in   XLEN            requester A write data
//  reqA_rdy  out  1               A accepted this cycle (combinational grant)
//  reqB_v    in   1               requester B write valid
//  reqB_sel  in   $clog2(NREG)    requester B destination register
//  reqB_i    in   XLEN            requester B write data
//  reqB_rdy  out  1               B accepted this cycle (combinational grant)
//  wen       out  1               to regfile write enable (registered)
//  regW_sel  out  $clog2(NREG)    to regfile write select (registered)
//  regW_i    out  XLEN            to regfile write data (registered)
//  pend_o    out  NREG            bit r set = write to r waiting (req valid, not yet written)
//  stall_cnt out  8               cycles a valid requester was refused, saturating
// BEHAVIOUR
//  - Reset (async, rst=1): wen=0, regW_sel=0, regW_i=0, stall_cnt=0, RR pointer=A; rdy outputs
//    follow combinational grant rules; pend_o reflects only the input valids (output stage empty).
//  - Handshake: transfer when reqX_v && reqX_rdy at rising edge. Requester holds v/sel/data stable
//    until accepted; dropping v before acceptance is legal (request withdrawn, no write).
//  - Grant: only one of reqA_rdy/reqB_rdy high per cycle. Single valid -> granted. Both valid ->
//    arbitration per CONFIGURATION. No valid -> both rdy low.
//  - Latency: accepted at edge N -> wen=1, regW_sel/regW_i = accepted values during cycle N+1;
//    regfile commits at edge N+1. Throughput one write per cycle, no bubbles.
//  - No grant at edge -> wen=0 next cycle; regW_sel/regW_i hold last value.
//  - x0 writes: accepted normally (rdy asserted, handshake completes) but wen stays 0; regW_sel/regW_i still load.
//  - Same destination from A and B together: serialised in grant order; later grant wins in regfile.
//  - pend_o = onehot(reqA_sel)&reqA_v | onehot(reqB_sel)&reqB_v | onehot(regW_sel)&wen; bit0 always 0.
//  - stall_cnt: +1 each cycle with a valid requester not granted; saturates at 255; cleared by rst only.
//  - rst asserted mid-stream: in-flight registered write discarded (wen drops immediately).
// CONFIGURATION
//  WB_ARB_RR_EN defined: round-robin. RR pointer selects winner on conflict; after any grant pointer
//    moves to the non-granted requester. Neither side waits more than one conflict cycle.
//  WB_ARB_RR_EN undefined: fixed priority, B (LSU) always wins conflicts; pointer logic absent.
// TESTING
//  1 Reset: rst=1 mid-write with wen=1 -> wen=0, stall_cnt=0 immediately, before next clk edge.
//  2 A only: reqA_v=1 sel=5 data=32'hDEADBEEF one cycle -> reqA_rdy=1; next cycle wen=1,
//    regW_sel=5, regW_i=DEADBEEF; regfile x5 reads DEADBEEF afterwards.
//  3 Conflict (RR_EN): A sel=3 and B sel=4 valid for 2 cycles -> cycle0 A granted, cycle1 B granted;
//    stall_cnt=1; x3/x4 written. Without RR_EN -> B first, then A.
//  4 x0 write: B sel=0 data=32'hFFFFFFFF -> reqB_rdy=1, wen stays 0, regfile x0 reads 0.
//  5 Same dest: A sel=7 data=1 and B sel=7 data=2 together -> two writes; x7 ends as data of
//    later grant (RR_EN: 2; fixed: 1); pend_o[7]=1 until final wen cycle ends.
//  6 Stream: 300 cycles both valid -> one wen per cycle, no gaps, stall_cnt saturates at 255.

Source files
------------

// File: rtl/regfile_wb_arb.sv
// Write-port arbiter for the single-write-port regfile (A = ALU, B = LSU).
// Define WB_ARB_RR_EN for round-robin conflicts; default is fixed B priority.
module regfile_wb_arb #(
    parameter  int XLEN = 32,
    parameter  int NREG = 32,
    localparam int SW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            reqA_v,
    input  logic [SW-1:0]   reqA_sel,
    input  logic [XLEN-1:0] reqA_i,
    output logic            reqA_rdy,
    input  logic            reqB_v,
    input  logic [SW-1:0]   reqB_sel,
    input  logic [XLEN-1:0] reqB_i,
    output logic            reqB_rdy,
    output logic            wen,
    output logic [SW-1:0]   regW_sel,
    output logic [XLEN-1:0] regW_i,
    output logic [NREG-1:0] pend_o,
    output logic [7:0]      stall_cnt
);

    logic win_a;
    logic refused;

`ifdef WB_ARB_RR_EN
    // ptr_b set means B wins the next conflict
    logic ptr_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_b <= 1'b0;
        end else if (reqA_rdy) begin
            ptr_b <= 1'b1;
        end else if (reqB_rdy) begin
            ptr_b <= 1'b0;
        end
    end

    assign win_a = ~ptr_b;
`else
    assign win_a = 1'b0;
`endif

    assign reqA_rdy = reqA_v & (~reqB_v | win_a);
    assign reqB_rdy = reqB_v & ~reqA_rdy;

    assign refused = (reqA_v & ~reqA_rdy) | (reqB_v & ~reqB_rdy);

    // x0 writes complete the handshake but never raise wen
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wen      <= 1'b0;
            regW_sel <= '0;
            regW_i   <= '0;
        end else begin
            unique case (1'b1)
                reqA_rdy: begin
                    wen      <= |reqA_sel;
                    regW_sel <= reqA_sel;
                    regW_i   <= reqA_i;
                end
                reqB_rdy: begin
                    wen      <= |reqB_sel;
                    regW_sel <= reqB_sel;
                    regW_i   <= reqB_i;
                end
                default: wen <= 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= 8'd0;
        end else if (refused && stall_cnt != 8'hFF) begin
            stall_cnt <= stall_cnt + 8'd1;
        end
    end

    always_comb begin
        pend_o = '0;
        if (reqA_v) pend_o[reqA_sel] = 1'b1;
        if (reqB_v) pend_o[reqB_sel] = 1'b1;
        if (wen)    pend_o[regW_sel] = 1'b1;
        pend_o[0] = 1'b0;
    end

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Bench for regfile_wb_arb: scoreboard of expected writes plus a regfile model.
// Expectations follow WB_ARB_RR_EN when the bench is built with it defined.
module tb_regfile_wb_arb;

`ifdef WB_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct packed {
        logic        wen;
        logic [4:0]  sel;
        logic [31:0] data;
    } wr_t;

    logic        clk;
    logic        rst;
    logic        reqA_v;
    logic [4:0]  reqA_sel;
    logic [31:0] reqA_i;
    logic        reqA_rdy;
    logic        reqB_v;
    logic [4:0]  reqB_sel;
    logic [31:0] reqB_i;
    logic        reqB_rdy;
    logic        wen;
    logic [4:0]  regW_sel;
    logic [31:0] regW_i;
    logic [31:0] pend_o;
    logic [7:0]  stall_cnt;

    int checks = 0;
    int errors = 0;

    wr_t         q[$];
    logic [31:0] rf[32];

    regfile_wb_arb dut (
        .clk(clk),
        .rst(rst),
        .reqA_v(reqA_v),
        .reqA_sel(reqA_sel),
        .reqA_i(reqA_i),
        .reqA_rdy(reqA_rdy),
        .reqB_v(reqB_v),
        .reqB_sel(reqB_sel),
        .reqB_i(reqB_i),
        .reqB_rdy(reqB_rdy),
        .wen(wen),
        .regW_sel(regW_sel),
        .regW_i(regW_i),
        .pend_o(pend_o),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // regfile model: commits on the edge that ends a wen cycle
    initial for (int i = 0; i < 32; i++) rf[i] = '0;
    always @(posedge clk)
        if (wen && regW_sel != 5'd0) rf[regW_sel] <= regW_i;

    task automatic drive(input logic av, input logic [4:0] as,
                         input logic [31:0] ad, input logic bv,
                         input logic [4:0] bs, input logic [31:0] bd);
        @(negedge clk);
        reqA_v   = av;
        reqA_sel = as;
        reqA_i   = ad;
        reqB_v   = bv;
        reqB_sel = bs;
        reqB_i   = bd;
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if (wen !== 1'b0 || regW_sel !== 5'd0 || regW_i !== 32'd0) begin
            errors++;
            $display("FAIL reset_out: wen=%b sel=%0d data=%h want 0/0/0",
                     wen, regW_sel, regW_i);
        end
        checks++;
        if (stall_cnt !== 8'd0 || pend_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: stall=%0d pend=%h want 0/0",
                     stall_cnt, pend_o);
        end
        checks++;
        if (reqA_rdy !== 1'b0 || reqB_rdy !== 1'b0) begin
            errors++;
            $display("FAIL reset_rdy: a=%b b=%b want 0/0", reqA_rdy, reqB_rdy);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_a_only;
        wr_t e;
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        #1;
        checks++;
        if (reqA_rdy !== 1'b1 || reqB_rdy !== 1'b0) begin
            errors++;
            $display("FAIL a_only_rdy: a=%b b=%b want 1/0", reqA_rdy, reqB_rdy);
        end
        checks++;
        if (pend_o !== 32'h20) begin
            errors++;
            $display("FAIL a_only_pend: got %h want %h", pend_o, 32'h20);
        end
        q.push_back('{1'b1, 5'd5, 32'hDEADBEEF});
        @(posedge clk);
        #1;
        e = q.pop_front();
        checks++;
        if ({wen, regW_sel, regW_i} !== e) begin
            errors++;
            $display("FAIL a_only_wr: got %b/%0d/%h want %b/%0d/%h",
                     wen, regW_sel, regW_i, e.wen, e.sel, e.data);
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #1;
        checks++;
        if (pend_o !== 32'h20) begin
            errors++;
            $display("FAIL a_only_pend_wen: got %h want %h", pend_o, 32'h20);
        end
        @(posedge clk);
        #1;
        checks++;
        if (wen !== 1'b0 || regW_sel !== 5'd5) begin
            errors++;
            $display("FAIL a_only_idle: wen=%b sel=%0d want 0/5", wen, regW_sel);
        end
        checks++;
        if (rf[5] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL a_only_rf: x5=%h want deadbeef", rf[5]);
        end
    endtask

    task automatic test_conflict;
        wr_t e;
        drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
        #1;
        checks++;
        if (reqA_rdy !== RR || reqB_rdy !== !RR) begin
            errors++;
            $display("FAIL conflict_rdy0: a=%b b=%b want %b/%b",
                     reqA_rdy, reqB_rdy, RR, !RR);
        end
        checks++;
        if (pend_o !== 32'h18) begin
            errors++;
            $display("FAIL conflict_pend: got %h want %h", pend_o, 32'h18);
        end
        q.push_back(RR ? wr_t'{1'b1, 5'd3, 32'h33} : wr_t'{1'b1, 5'd4, 32'h44});
        @(posedge clk);
        #1;
        e = q.pop_front();
        checks++;
        if ({wen, regW_sel, regW_i} !== e) begin
            errors++;
            $display("FAIL conflict_wr0: got %b/%0d/%h want %b/%0d/%h",
                     wen, regW_sel, regW_i, e.wen, e.sel, e.data);
        end
        checks++;
        if (stall_cnt !== 8'd1) begin
            errors++;
            $display("FAIL conflict_stall: got %0d want 1", stall_cnt);
        end
        drive(!RR, 5'd3, 32'h33, RR, 5'd4, 32'h44);
        #1;
        checks++;
        if (reqA_rdy !== !RR || reqB_rdy !== RR) begin
            errors++;
            $display("FAIL conflict_rdy1: a=%b b=%b want %b/%b",
                     reqA_rdy, reqB_rdy, !RR, RR);
        end
        q.push_back(RR ? wr_t'{1'b1, 5'd4, 32'h44} : wr_t'{1'b1, 5'd3, 32'h33});
        @(posedge clk);
        #1;
        e = q.pop_front();
        checks++;
        if ({wen, regW_sel, regW_i} !== e) begin
            errors++;
            $display("FAIL conflict_wr1: got %b/%0d/%h want %b/%0d/%h",
                     wen, regW_sel, regW_i, e.wen, e.sel, e.data);
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(posedge clk);
        #1;
        checks++;
        if (rf[3] !== 32'h33 || rf[4] !== 32'h44 || stall_cnt !== 8'd1) begin
            errors++;
            $display("FAIL conflict_rf: x3=%h x4=%h stall=%0d want 33/44/1",
                     rf[3], rf[4], stall_cnt);
        end
    endtask

    task automatic test_x0;
        wr_t e;
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFFFFFF);
        #1;
        checks++;
        if (reqB_rdy !== 1'b1 || reqA_rdy !== 1'b0 || pend_o !== 32'd0) begin
            errors++;
            $display("FAIL x0_rdy: a=%b b=%b pend=%h want 0/1/0",
                     reqA_rdy, reqB_rdy, pend_o);
        end
        q.push_back('{1'b0, 5'd0, 32'hFFFFFFFF});
        @(posedge clk);
        #1;
        e = q.pop_front();
        checks++;
        if ({wen, regW_sel, regW_i} !== e) begin
            errors++;
            $display("FAIL x0_wr: got %b/%0d/%h want %b/%0d/%h",
                     wen, regW_sel, regW_i, e.wen, e.sel, e.data);
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(posedge clk);
        #1;
        checks++;
        if (rf[0] !== 32'd0) begin
            errors++;
            $display("FAIL x0_rf: x0=%h want 0", rf[0]);
        end
    endtask

    task automatic test_same_dest;
        wr_t e;
        drive(1'b1, 5'd7, 32'd1, 1'b1, 5'd7, 32'd2);
        #1;
        checks++;
        if (reqA_rdy !== RR || reqB_rdy !== !RR || pend_o[7] !== 1'b1) begin
            errors++;
            $display("FAIL same_rdy0: a=%b b=%b p7=%b want %b/%b/1",
                     reqA_rdy, reqB_rdy, pend_o[7], RR, !RR);
        end
        q.push_back(RR ? wr_t'{1'b1, 5'd7, 32'd1} : wr_t'{1'b1, 5'd7, 32'd2});
        q.push_back(RR ? wr_t'{1'b1, 5'd7, 32'd2} : wr_t'{1'b1, 5'd7, 32'd1});
        @(posedge clk);
        #1;
        e = q.pop_front();
        checks++;
        if ({wen, regW_sel, regW_i} !== e) begin
            errors++;
            $display("FAIL same_wr0: got %b/%0d/%h want %b/%0d/%h",
                     wen, regW_sel, regW_i, e.wen, e.sel, e.data);
        end
        drive(!RR, 5'd7, 32'd1, RR, 5'd7, 32'd2);
        #1;
        checks++;
        if (pend_o[7] !== 1'b1) begin
            errors++;
            $display("FAIL same_pend1: p7=%b want 1", pend_o[7]);
        end
        @(posedge clk);
        #1;
        e = q.pop_front();
        checks++;
        if ({wen, regW_sel, regW_i} !== e) begin
            errors++;
            $display("FAIL same_wr1: got %b/%0d/%h want %b/%0d/%h",
                     wen, regW_sel, regW_i, e.wen, e.sel, e.data);
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #1;
        checks++;
        if (pend_o[7] !== 1'b1) begin
            errors++;
            $display("FAIL same_pend2: p7=%b want 1", pend_o[7]);
        end
        @(posedge clk);
        #1;
        checks++;
        if (pend_o[7] !== 1'b0 || rf[7] !== (RR ? 32'd2 : 32'd1)) begin
            errors++;
            $display("FAIL same_final: p7=%b x7=%h want 0/%h",
                     pend_o[7], rf[7], RR ? 32'd2 : 32'd1);
        end
        checks++;
        if (stall_cnt !== 8'd2) begin
            errors++;
            $display("FAIL same_stall: got %0d want 2", stall_cnt);
        end
    endtask

    task automatic test_stream;
        wr_t         e;
        logic [31:0] ca;
        logic [31:0] cb;
        logic        ea;
        int          es;
        ca = 32'h1000;
        cb = 32'h2000;
        es = 2;
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 5'd10, ca, 1'b1, 5'd11, cb);
            #1;
            ea = RR && (i % 2 == 0);
            checks++;
            if (reqA_rdy !== ea || reqB_rdy !== !ea) begin
                errors++;
                $display("FAIL stream_rdy[%0d]: a=%b b=%b want %b/%b",
                         i, reqA_rdy, reqB_rdy, ea, !ea);
            end
            q.push_back(ea ? wr_t'{1'b1, 5'd10, ca} : wr_t'{1'b1, 5'd11, cb});
            @(posedge clk);
            #1;
            e = q.pop_front();
            checks++;
            if ({wen, regW_sel, regW_i} !== e) begin
                errors++;
                $display("FAIL stream_wr[%0d]: got %b/%0d/%h want %b/%0d/%h",
                         i, wen, regW_sel, regW_i, e.wen, e.sel, e.data);
            end
            es = (es < 255) ? es + 1 : 255;
            checks++;
            if (stall_cnt !== 8'(es)) begin
                errors++;
                $display("FAIL stream_stall[%0d]: got %0d want %0d",
                         i, stall_cnt, es);
            end
            if (ea) ca = ca + 32'd1;
            else    cb = cb + 32'd1;
        end
    endtask

    task automatic test_reset_mid;
        drive(1'b1, 5'd9, 32'h5, 1'b0, 5'd0, 32'd0);
        @(posedge clk);
        #1;
        checks++;
        if (wen !== 1'b1 || stall_cnt !== 8'd255) begin
            errors++;
            $display("FAIL mid_pre: wen=%b stall=%0d want 1/255", wen, stall_cnt);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (wen !== 1'b0 || stall_cnt !== 8'd0 || regW_sel !== 5'd0) begin
            errors++;
            $display("FAIL mid_rst: wen=%b stall=%0d sel=%0d want 0/0/0",
                     wen, stall_cnt, regW_sel);
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (rf[9] !== 32'd0 || q.size() != 0) begin
            errors++;
            $display("FAIL mid_discard: x9=%h queue=%0d want 0/0",
                     rf[9], q.size());
        end
    endtask

    initial begin
        rst      = 1'b1;
        reqA_v   = 1'b0;
        reqA_sel = '0;
        reqA_i   = '0;
        reqB_v   = 1'b0;
        reqB_sel = '0;
        reqB_i   = '0;
        test_reset;
        test_a_only;
        test_conflict;
        test_x0;
        test_same_dest;
        test_stream;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
